mining_target_check: RTL and testbench
======================================

# mining_target_check

Serial difficulty comparator sitting directly upstream of the mining control FSM. It takes each 256-bit double-SHA digest produced for the current nonce, compares it word-serially against a 256-bit target, and produces the `fine_mining` hit flag and a `done` strobe that the FSM consumes before it either reports "Trovato!" or advances the nonce. The compare costs one cycle per 32-bit word and exits early on the first unequal word.

## Interface
- `WORD_W`, 32, compare slice width in bits.
- `NWORDS`, 8, number of slices; digest/target width = `WORD_W*NWORDS` (256).

- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs immediately.
- `target_load`  in  1  when high at an edge, `target_in` is written to the pending-target register.
- `target_in`  in  256  new target, unsigned, bit 255 = MSB.
- `digest_valid`  in  1  single-cycle request; accepted only when `busy`=0.
- `digest`  in  256  hash to check, sampled at the accepting edge.
- `busy`  out  1  compare in progress.
- `done`  out  1  one-cycle pulse, compare finished.
- `fine_mining`  out  1  level; 1 = last checked digest ≤ target.
- `err_overrun`  out  1  sticky; set when `digest_valid` arrives while `busy`=1.
- `hit_count`  out  32  number of hits (see Configuration).

## Operation
- Reset values: `busy`=0, `done`=0, `fine_mining`=0, `err_overrun`=0, `hit_count`=0, pending and working target = 0, state IDLE.
- States: IDLE, CMP.
- Pending target is written by `target_load` in any state; working target is copied from pending at digest acceptance, so a load during CMP affects only the next digest. `target_load` and acceptance on the same edge: the new `target_in` is used.
- IDLE + `digest_valid`: capture digest, copy target, word index ← NWORDS-1, clear `fine_mining`, go to CMP.
- CMP, per edge, word `idx` (bits `idx*32+31 : idx*32`, most significant first), unsigned:
  - digest word < target word: hit, finish.
  - digest word > target word: miss, finish.
  - equal and idx>0: idx ← idx-1, stay.
  - equal and idx=0: digests equal → hit, finish.
- Finish: `fine_mining` ← hit, `done` ← 1 for one cycle, state ← IDLE, `busy` ← 0.
- `fine_mining` holds until the next accepted digest or reset.
- `digest_valid` while `busy`=1: ignored, `err_overrun` ← 1 (sticky until reset), ongoing compare unaffected.
- Boundaries: target all-ones always hits; target zero hits only for digest zero.

## Timing
- Acceptance edge E0; word NWORDS-1 evaluated at E1; deciding edge Ek, k ∈ 1..8 = words examined.
- `done`/`fine_mining` visible in the cycle after Ek: latency 1 cycle best, 8 worst.
- `busy` high from after E0 through Ek; low in the `done` cycle, so a new `digest_valid` may be accepted in the same cycle `done` is high (back-to-back, no bubble).
- Reset mid-compare: outputs drop asynchronously, no `done` is produced, next digest starts clean.

## Configuration
- `MINING_HIT_COUNT_EN` defined: `hit_count` increments by 1 at every deciding edge that yields a hit; wraps 0xFFFFFFFF → 0; cleared only by reset.
- Not defined: counter logic omitted; `hit_count` port present and tied to 0.

## Test plan
- Target word7=0x0000FFFF, others 0xFFFFFFFF; digest word7=0x00001234 → `done` after E1, `fine_mining`=1.
- Digest == target (any value, e.g. all 0xA5A5A5A5) → `done` after E8, `fine_mining`=1.
- Digest word7 equal, word6 = target word6 + 1 → `done` after E2, `fine_mining`=0.
- `digest_valid` pulsed at E2 of a running compare → ignored, `err_overrun`=1, first result unchanged; `target_load` during CMP applies only to next digest.
- `reset` asserted after E3 → all outputs 0 at once, no `done` pulse; subsequent digest completes normally.
- With `MINING_HIT_COUNT_EN`: 3 hits and 2 misses back-to-back (each `digest_valid` in `done` cycle) → `hit_count`=3; without macro → `hit_count`=0.

Source files
------------

// File: rtl/mining_target_check.sv
// rtl/mining_target_check.sv - word-serial digest <= target comparator with early exit
// Optional hit counter enabled by defining MINING_HIT_COUNT_EN.
module mining_target_check #(
  parameter int WORD_W = 32,
  parameter int NWORDS = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       target_load,
  input  logic [WORD_W*NWORDS-1:0]   target_in,
  input  logic                       digest_valid,
  input  logic [WORD_W*NWORDS-1:0]   digest,
  output logic                       busy,
  output logic                       done,
  output logic                       fine_mining,
  output logic                       err_overrun,
  output logic [31:0]                hit_count
);

  localparam int DW = WORD_W * NWORDS;
  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NWORDS - 1);

  typedef enum logic {IDLE, CMP} state_t;

  state_t            state_q;
  logic [DW-1:0]     pend_tgt_q;
  logic [DW-1:0]     work_tgt_q;
  logic [DW-1:0]     work_tgt_d;
  logic [DW-1:0]     dig_q;
  logic [IW-1:0]     idx_q;
  logic              busy_q;
  logic              done_q;
  logic              fine_q;
  logic              err_q;

  logic [WORD_W-1:0] dig_word;
  logic [WORD_W-1:0] tgt_word;
  logic              word_lt;
  logic              word_gt;
  logic              finish;
  logic              hit;

  always_comb begin
    dig_word = '0;
    tgt_word = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (idx_q == IW'(i)) begin
        dig_word = dig_q[i*WORD_W +: WORD_W];
        tgt_word = work_tgt_q[i*WORD_W +: WORD_W];
      end
    end
  end

  assign word_lt = (dig_word < tgt_word);
  assign word_gt = (dig_word > tgt_word);
  // Equal on the last word means digest == target, which still counts as a hit.
  assign finish  = (state_q == CMP) && (word_lt || word_gt || (idx_q == '0));
  assign hit     = finish && !word_gt;

  // A load on the accepting edge must win over the stale pending value.
  assign work_tgt_d = target_load ? target_in : pend_tgt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_tgt_q <= '0;
      work_tgt_q <= '0;
      dig_q      <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fine_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (target_load) pend_tgt_q <= target_in;
      if (digest_valid && busy_q) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (digest_valid) begin
            dig_q      <= digest;
            work_tgt_q <= work_tgt_d;
            idx_q      <= IDX_TOP;
            fine_q     <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= CMP;
          end
        end
        CMP: begin
          if (finish) begin
            fine_q  <= hit;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MINING_HIT_COUNT_EN
  logic [31:0] hit_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) hit_cnt_q <= '0;
    else if (hit) hit_cnt_q <= hit_cnt_q + 32'd1;
  end

  assign hit_count = hit_cnt_q;
`else
  assign hit_count = '0;
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign fine_mining = fine_q;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_mining_target_check.sv
// tb/tb_mining_target_check.sv - table-driven scoreboard bench for mining_target_check
module tb_mining_target_check;

  logic         clock;
  logic         reset;
  logic         target_load;
  logic [255:0] target_in;
  logic         digest_valid;
  logic [255:0] digest;
  logic         busy;
  logic         done;
  logic         fine_mining;
  logic         err_overrun;
  logic [31:0]  hit_count;

  mining_target_check #(.WORD_W(32), .NWORDS(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .target_load  (target_load),
    .target_in    (target_in),
    .digest_valid (digest_valid),
    .digest       (digest),
    .busy         (busy),
    .done         (done),
    .fine_mining  (fine_mining),
    .err_overrun  (err_overrun),
    .hit_count    (hit_count)
  );

  typedef struct {
    logic [255:0] tgt;
    logic [255:0] dig;
    logic         hit;
    int           k;
  } vec_t;

  typedef struct {
    logic hit;
    int   k;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           exp_hits = 0;
  logic [255:0] pend_tgt = '0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain 256-bit unsigned compare; k = position of first differing word from the top.
  function automatic void model(input logic [255:0] t, input logic [255:0] d,
                                output logic h, output int k);
    h = (d <= t);
    k = 8;
    for (int i = 7; i >= 0; i--) begin
      if (d[i*32 +: 32] != t[i*32 +: 32]) begin
        k = 8 - i;
        break;
      end
    end
  endfunction

  always @(negedge clock) begin
    if (reset) begin
      cyc = 0;
    end else begin
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("fine_mining", {63'd0, fine_mining}, {63'd0, e.hit});
          check("latency", 64'(cyc), 64'(e.k));
          if (e.hit) exp_hits++;
        end
        cyc = 0;
      end
      if (busy) cyc++;
    end
  end

  task automatic send(input logic ld, input logic [255:0] t, input logic [255:0] d,
                      input logic h, input int k);
    exp_t e;
    e.hit = h;
    e.k   = k;
    sb.push_back(e);
    if (ld) pend_tgt = t;
    target_load  = ld;
    target_in    = t;
    digest_valid = 1'b1;
    digest       = d;
    @(negedge clock);
    target_load  = 1'b0;
    digest_valid = 1'b0;
  endtask

  task automatic send_model(input logic ld, input logic [255:0] t, input logic [255:0] d);
    logic h;
    int   k;
    model(ld ? t : pend_tgt, d, h, k);
    send(ld, t, d, h, k);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      if (done) return;
      @(negedge clock);
    end
    check("done_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [31:0] exp_count();
`ifdef MINING_HIT_COUNT_EN
    return 32'(exp_hits);
`else
    return 32'd0;
`endif
  endfunction

  vec_t tbl[10];

  initial begin
    logic [255:0] t;
    logic [255:0] d;
    int p;

    tbl[0] = '{{32'h0000FFFF, {7{32'hFFFFFFFF}}}, {32'h00001234, 224'h0}, 1'b1, 1};
    tbl[1] = '{{8{32'hA5A5A5A5}}, {8{32'hA5A5A5A5}}, 1'b1, 8};
    tbl[2] = '{{8{32'hA5A5A5A5}}, {32'hA5A5A5A5, 32'hA5A5A5A6, {6{32'hA5A5A5A5}}}, 1'b0, 2};
    tbl[3] = '{{8{32'hFFFFFFFF}}, {8{32'hFFFFFFFF}}, 1'b1, 8};
    tbl[4] = '{{8{32'hFFFFFFFF}}, 256'h0, 1'b1, 1};
    tbl[5] = '{256'h0, 256'h0, 1'b1, 8};
    tbl[6] = '{256'h0, 256'h1, 1'b0, 8};
    tbl[7] = '{256'h0, {32'h80000000, 224'h0}, 1'b0, 1};
    tbl[8] = '{{8{32'h12345678}}, {{7{32'h12345678}}, 32'h12345677}, 1'b1, 8};
    tbl[9] = '{{8{32'h12345678}}, {{4{32'h12345678}}, 32'h12345679, {3{32'h0}}}, 1'b0, 5};

    reset        = 1'b1;
    target_load  = 1'b0;
    target_in    = '0;
    digest_valid = 1'b0;
    digest       = '0;
    @(negedge clock);
    @(negedge clock);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_fine", {63'd0, fine_mining}, 64'd0);
    check("rst_err", {63'd0, err_overrun}, 64'd0);
    check("rst_hit_count", {32'd0, hit_count}, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Table vectors, each issued in the done cycle of the previous one.
    for (int i = 0; i < 10; i++) begin
      send(1'b1, tbl[i].tgt, tbl[i].dig, tbl[i].hit, tbl[i].k);
      wait_done();
    end

    for (int i = 0; i < 8; i++) begin
      t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      d = t;
      p = $urandom_range(0, 7);
      d[p*32 +: 32] = $urandom;
      send_model(1'b1, t, d);
      wait_done();
    end
    @(negedge clock);
    check("err_clean", {63'd0, err_overrun}, 64'd0);
    check("hit_count_table", {32'd0, hit_count}, {32'd0, exp_count()});

    // Overrun during compare plus a target load that must only affect the next digest.
    send(1'b1, {8{32'hA5A5A5A5}}, {8{32'hA5A5A5A5}}, 1'b1, 8);
    @(negedge clock);
    digest_valid = 1'b1;
    digest       = '0;
    target_load  = 1'b1;
    target_in    = '0;
    pend_tgt     = '0;
    @(negedge clock);
    digest_valid = 1'b0;
    target_load  = 1'b0;
    check("err_overrun_set", {63'd0, err_overrun}, 64'd1);
    check("busy_after_overrun", {63'd0, busy}, 64'd1);
    wait_done();
    send(1'b0, '0, {32'h00000001, 224'h0}, 1'b0, 1);
    wait_done();
    check("err_sticky", {63'd0, err_overrun}, 64'd1);

    // Reset in the middle of a long compare, with fine_mining previously high.
    send(1'b1, {8{32'hFFFFFFFF}}, 256'h0, 1'b1, 1);
    wait_done();
    send(1'b1, {8{32'hA5A5A5A5}}, {8{32'hA5A5A5A5}}, 1'b1, 8);
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    check("busy_before_reset", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    sb.delete();
    exp_hits = 0;
    pend_tgt = '0;
    #1;
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_done", {63'd0, done}, 64'd0);
    check("mid_rst_fine", {63'd0, fine_mining}, 64'd0);
    check("mid_rst_err", {63'd0, err_overrun}, 64'd0);
    check("mid_rst_hit_count", {32'd0, hit_count}, 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);

    // Three hits and two misses back-to-back.
    send(1'b1, {32'h0000FFFF, {7{32'hFFFFFFFF}}}, {32'h00001234, 224'h0}, 1'b1, 1);
    wait_done();
    send(1'b1, {8{32'hA5A5A5A5}}, {32'hA5A5A5A5, 32'hA5A5A5A6, {6{32'hA5A5A5A5}}}, 1'b0, 2);
    wait_done();
    send(1'b1, {8{32'hA5A5A5A5}}, {8{32'hA5A5A5A5}}, 1'b1, 8);
    wait_done();
    send(1'b1, 256'h0, {32'h80000000, 224'h0}, 1'b0, 1);
    wait_done();
    send(1'b1, {8{32'h12345678}}, {{7{32'h12345678}}, 32'h12345677}, 1'b1, 8);
    wait_done();
    @(negedge clock);
    check("exp_hits_bench", 64'(exp_hits), 64'd3);
    check("hit_count_final", {32'd0, hit_count}, {32'd0, exp_count()});
    check("err_after_reset", {63'd0, err_overrun}, 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
